// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: in-order pipe writes always win, a one-entry buffer holds MDU results.
// Optional starvation stall (wait counter + stall_req) is built only when WBARB_STALL_EN is defined.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wdata,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_wdata,
  output logic        mdu_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        pend_valid,
  output logic [4:0]  pend_rd,
  output logic        stall_req
);

  logic        pend_valid_q, pend_valid_d;
  logic [4:0]  pend_rd_q,    pend_rd_d;
  logic [31:0] pend_data_q,  pend_data_d;
  logic        mdu_ready_q,  mdu_ready_d;
  logic        rf_wen_q,     rf_wen_d;
  logic [4:0]  rf_rd_q,      rf_rd_d;
  logic [31:0] rf_wdata_q,   rf_wdata_d;
  logic        pipe_eff;
  logic        mdu_acc;
  logic        release_buf;

  // Arbitration: pipe write wins, otherwise drain; a WAW hit kills the stale buffered result.
  always_comb begin
    pipe_eff    = pipe_wen && (pipe_rd != 5'd0);
    mdu_acc     = mdu_valid && mdu_ready_q;
    release_buf = pend_valid_q && (!pipe_eff || (pipe_rd == pend_rd_q));
    rf_rd_d     = rf_rd_q;
    rf_wdata_d  = rf_wdata_q;
    rf_wen_d    = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_rd_d    = pend_rd_q;
    pend_data_d  = pend_data_q;
    if (pipe_eff) begin
      rf_wen_d   = 1'b1;
      rf_rd_d    = pipe_rd;
      rf_wdata_d = pipe_wdata;
    end else if (pend_valid_q) begin
      rf_wen_d   = 1'b1;
      rf_rd_d    = pend_rd_q;
      rf_wdata_d = pend_data_q;
    end else begin
      rf_wen_d   = 1'b0;
    end
    if (release_buf) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
    // Acceptance only happens while EMPTY, so it never races a drain; x0 results are dropped.
    if (mdu_acc && (mdu_rd != 5'd0)) begin
      pend_valid_d = 1'b1;
      pend_rd_d    = mdu_rd;
      pend_data_d  = mdu_wdata;
    end else begin
      pend_rd_d    = pend_rd_q;
      pend_data_d  = pend_data_q;
    end
    mdu_ready_d = !pend_valid_d;
  end

  // State and registered output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_rd_q    <= 5'd0;
      pend_data_q  <= 32'd0;
      mdu_ready_q  <= 1'b1;
      rf_wen_q     <= 1'b0;
      rf_rd_q      <= 5'd0;
      rf_wdata_q   <= 32'd0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      pend_data_q  <= pend_data_d;
      mdu_ready_q  <= mdu_ready_d;
      rf_wen_q     <= rf_wen_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

`ifdef WBARB_STALL_EN
  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);
  logic [3:0] wait_q, wait_d;
  logic       stall_q, stall_d;

  // Age of the held result; restarts on entry and clears when the buffer empties.
  always_comb begin
    if (!pend_valid_d || !pend_valid_q) begin
      wait_d = 4'd0;
    end else if (wait_q == 4'hF) begin
      wait_d = wait_q;
    end else begin
      wait_d = wait_q + 4'd1;
    end
    stall_d = pend_valid_d && (wait_d >= LIMIT_C);
  end

  // Wait counter and stall request flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q  <= 4'd0;
      stall_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign stall_req = stall_q;
`else
  assign stall_req = 1'b0;
`endif

  assign mdu_ready  = mdu_ready_q;
  assign rf_wen     = rf_wen_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wdata   = rf_wdata_q;
  assign pend_valid = pend_valid_q;
  assign pend_rd    = pend_rd_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_regfile_wb_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_wen;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_wdata;
  logic        mdu_ready, rf_wen, pend_valid, stall_req;
  logic [4:0]  rf_rd, pend_rd;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  // Reference model: one optional held result with its age, plus the last register-file write.
  bit          m_held;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          m_age;
  bit          e_wen;
  logic [4:0]  e_rd;
  logic [31:0] e_wd;
  logic [31:0] mdu_seen [32];

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_wdata(mdu_wdata),
    .mdu_ready(mdu_ready),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_rd(pend_rd), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_stall();
`ifdef WBARB_STALL_EN
    return m_held && (m_age >= LIMIT);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    m_held = 0; m_rd = 5'd0; m_data = 32'd0; m_age = 0;
    e_wen = 0; e_rd = 5'd0; e_wd = 32'd0;
  endfunction

  function automatic void model_cycle();
    bit was_empty = !m_held;
    if (pipe_wen && pipe_rd != 5'd0) begin
      e_wen = 1; e_rd = pipe_rd; e_wd = pipe_wdata;
      if (m_held && m_rd == pipe_rd) m_held = 0;
      else if (m_held) m_age = (m_age >= 15) ? 15 : m_age + 1;
    end else if (m_held) begin
      e_wen = 1; e_rd = m_rd; e_wd = m_data; m_held = 0;
    end else begin
      e_wen = 0;
    end
    if (was_empty && mdu_valid && mdu_rd != 5'd0) begin
      m_held = 1; m_rd = mdu_rd; m_data = mdu_wdata; m_age = 0;
    end
    if (!m_held) m_age = 0;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".rf_wen"}, 32'(rf_wen), 32'(e_wen));
    if (e_wen) begin
      check({tag, ".rf_rd"}, 32'(rf_rd), 32'(e_rd));
      check({tag, ".rf_wdata"}, rf_wdata, e_wd);
    end
    check({tag, ".pend_valid"}, 32'(pend_valid), 32'(m_held));
    if (m_held) check({tag, ".pend_rd"}, 32'(pend_rd), 32'(m_rd));
    check({tag, ".mdu_ready"}, 32'(mdu_ready), 32'(!m_held));
    check({tag, ".stall_req"}, 32'(stall_req), 32'(exp_stall()));
  endtask

  task automatic drive(input bit pw, input logic [4:0] prd, input logic [31:0] pwd,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] mwd);
    pipe_wen = pw; pipe_rd = prd; pipe_wdata = pwd;
    mdu_valid = mv; mdu_rd = mrd; mdu_wdata = mwd;
  endtask

  task automatic step(input string tag);
    model_cycle();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    model_reset();
    #2;
    check("reset.pend_valid", 32'(pend_valid), 32'd0);
    check("reset.rf_wen", 32'(rf_wen), 32'd0);
    check("reset.rf_rd", 32'(rf_rd), 32'd0);
    check("reset.rf_wdata", rf_wdata, 32'd0);
    check("reset.stall_req", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step("idle");
    check("idle.mdu_ready", 32'(mdu_ready), 32'd1);

    // MDU alone
    drive(0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF);
    step("mdu.e1");
    check("mdu.e1.pend", 32'(pend_valid), 32'd1);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step("mdu.e2");
    check("mdu.e2.wdata", rf_wdata, 32'hDEADBEEF);
    check("mdu.e2.ready", 32'(mdu_ready), 32'd1);

    // Collision: pipe wins, buffer waits, drains next cycle
    drive(0, 5'd0, 32'd0, 1, 5'd7, 32'h7777);
    step("col.load");
    drive(1, 5'd3, 32'h11, 0, 5'd0, 32'd0);
    step("col.pipe");
    check("col.pipe.rd", 32'(rf_rd), 32'd3);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step("col.drain");
    check("col.drain.rd", 32'(rf_rd), 32'd7);

    // WAW: same destination kills the held result
    drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h9999);
    step("waw.load");
    drive(1, 5'd9, 32'h22, 0, 5'd0, 32'd0);
    step("waw.pipe");
    check("waw.pend", 32'(pend_valid), 32'd0);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step("waw.after");
    check("waw.no_write", 32'(rf_wen), 32'd0);

    // Starvation: pipe busy every cycle, then one free cycle
    drive(0, 5'd0, 32'd0, 1, 5'd12, 32'hC0C0);
    step("starve.load");
    for (int i = 0; i < 6; i++) begin
      drive(1, 5'(i + 1), 32'(i), 0, 5'd0, 32'd0);
      step("starve.busy");
`ifdef WBARB_STALL_EN
      check("starve.stall", 32'(stall_req), 32'(i >= 3));
`endif
    end
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step("starve.drain");
    check("starve.stall_low", 32'(stall_req), 32'd0);

    // x0 handling: pipe to x0 is a free cycle; MDU to x0 is dropped
    drive(0, 5'd0, 32'd0, 1, 5'd4, 32'h4444);
    step("x0.load");
    drive(1, 5'd0, 32'hBAD, 0, 5'd0, 32'd0);
    step("x0.pipe");
    check("x0.drain_rd", 32'(rf_rd), 32'd4);
    drive(0, 5'd0, 32'd0, 1, 5'd0, 32'h5555);
    step("x0.mdu");
    check("x0.mdu_pend", 32'(pend_valid), 32'd0);

    // Async reset while HELD
    drive(1, 5'd2, 32'h2, 1, 5'd6, 32'h6666);
    step("ar.load");
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("ar.pend_valid", 32'(pend_valid), 32'd0);
    check("ar.rf_wen", 32'(rf_wen), 32'd0);
    check("ar.stall_req", 32'(stall_req), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    step("ar.after1");
    step("ar.after2");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] prd;
      prd = ($urandom_range(0, 3) == 0 && m_held) ? m_rd : 5'($urandom_range(0, 31));
      drive(bit'($urandom_range(0, 1)), prd, $urandom(),
            bit'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom());
      if (mdu_valid && !m_held) mdu_seen[mdu_rd] = mdu_wdata;
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
